// File: rtl/is_scoreboard.sv
// Issue-stage scoreboard: per-register ready countdowns for long-latency producers,
// a zero-latency RAW stall decision for the launch-queue head, and a stall-cycle counter.
module is_scoreboard #(
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 2,
    parameter int CNT_W    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_all,
    input  logic        es_allowin,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rj,
    input  logic        issue_rj_used,
    input  logic [4:0]  issue_rkd,
    input  logic        issue_rkd_used,
    input  logic        issue_gr_we,
    input  logic [4:0]  issue_dest,
    input  logic [1:0]  issue_lat_cls,
    output logic        issue_stall,
    output logic        issue_fire,
    output logic [31:0] pending_mask,
    output logic [31:0] stall_cnt
);

    localparam logic [1:0] CLS_LOAD = 2'd1;
    localparam logic [1:0] CLS_MUL  = 2'd2;

    // r0 has no storage: it can never be pending
    logic [CNT_W-1:0] cnt_q [1:31];
    logic [CNT_W-1:0] cnt_d [1:31];
    logic [31:0]      pending;
    logic [31:0]      stall_cnt_q;
    logic [31:0]      stall_cnt_d;
    logic             rj_hazard;
    logic             rkd_hazard;
    logic             stall_w;
    logic             fire_w;

    always_comb begin
        pending = '0;
        for (int i = 1; i < 32; i++) begin
            pending[i] = (cnt_q[i] != '0);
        end
    end

    always_comb begin
        rj_hazard  = issue_rj_used  && (issue_rj  != 5'd0) && pending[issue_rj];
        rkd_hazard = issue_rkd_used && (issue_rkd != 5'd0) && pending[issue_rkd];
        stall_w    = issue_valid && (rj_hazard || rkd_hazard);
        fire_w     = issue_valid && !stall_w && es_allowin;
    end

    // Flush beats a new producer; a new producer's value beats the decrement (WAW: youngest wins)
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush_all) begin
                cnt_d[i] = '0;
            end else if (fire_w && issue_gr_we && (issue_dest == 5'(i))) begin
                case (issue_lat_cls)
                    CLS_LOAD: cnt_d[i] = CNT_W'(LOAD_LAT);
                    CLS_MUL:  cnt_d[i] = CNT_W'(MUL_LAT);
                    default:  cnt_d[i] = '0;
                endcase
            end else if (es_allowin && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_w && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_stall  = stall_w;
    assign issue_fire   = fire_w;
    assign pending_mask = pending;
    assign stall_cnt    = stall_cnt_q;

endmodule
